// File: rtl/dds_sweep_pkg.sv
// Shared types and constants for the DDS frequency-sweep sequencer:
// FSM state encoding, default widths and the saturating tuning-word add.
package dds_sweep_pkg;

    localparam int FWORD_W  = 28;
    localparam int IDX_W    = 10;
    localparam int SETTLE_W = 16;
    localparam int DWELL_W  = 24;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DWELL,
        DONE
    } sweep_state_t;

    typedef struct packed {
        logic               sat;
        logic [FWORD_W-1:0] word;
    } sat_word_t;

    // One extra bit catches the carry; on carry the word pins at all-ones.
    function automatic sat_word_t sat_add(input logic [FWORD_W-1:0] a,
                                          input logic [FWORD_W-1:0] b);
        logic [FWORD_W:0] sum;
        sat_word_t        r;
        sum    = {1'b0, a} + {1'b0, b};
        r.sat  = sum[FWORD_W];
        r.word = sum[FWORD_W] ? {FWORD_W{1'b1}} : sum[FWORD_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/sweep_interval_cnt.sv
// Loadable down-counter for settle/dwell intervals. A length of 0 behaves
// as 1; term is high on the final enabled cycle of the interval.
module sweep_interval_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] len,
    output logic         term
);

    logic [W-1:0] remain;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesized logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= '0;
        end else if (load) begin
            remain <= (len == '0) ? '0 : len - W'(1);
        end else if (en && remain != '0) begin
            remain <= remain - W'(1);
        end
    end

    assign term = en && (remain == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS tuning word: per point it settles,
// opens a measurement window, then steps. `DDS_SWEEP_LOOP_EN adds sweep_loop.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int FWORD_W  = dds_sweep_pkg::FWORD_W,
    parameter int IDX_W    = dds_sweep_pkg::IDX_W,
    parameter int SETTLE_W = dds_sweep_pkg::SETTLE_W,
    parameter int DWELL_W  = dds_sweep_pkg::DWELL_W
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DDS_SWEEP_LOOP_EN
    input  logic                sweep_loop,
`endif
    input  logic                start,
    input  logic                abort,
    input  logic [FWORD_W-1:0]  f_start,
    input  logic [FWORD_W-1:0]  f_step,
    input  logic [IDX_W-1:0]    n_points,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [DWELL_W-1:0]  dwell_cycles,
    output logic [FWORD_W-1:0]  fre_w,
    output logic                busy,
    output logic                meas_window,
    output logic                point_valid,
    output logic [IDX_W-1:0]    point_idx,
    output logic                done,
    output logic                ovf
);

    sweep_state_t state, next_state;

    logic                capture, settle_load, dwell_load, advance, wrap;
    logic                settle_term, dwell_term, loop_req, last_point, wrap_done;
    logic [FWORD_W-1:0]  cfg_start, cfg_step;
    logic [IDX_W-1:0]    last_idx;
    logic [SETTLE_W-1:0] cfg_settle, settle_len;
    logic [DWELL_W-1:0]  cfg_dwell;
    sat_word_t           step_sum;

`ifdef DDS_SWEEP_LOOP_EN
    assign loop_req = sweep_loop;
`else
    assign loop_req = 1'b0;
`endif

    // The first settle interval loads straight from the port, before capture lands.
    assign settle_len = capture ? settle_cycles : cfg_settle;
    assign last_point = (point_idx == last_idx);
    assign step_sum   = sat_add(fre_w, cfg_step);

    sweep_interval_cnt #(.W(SETTLE_W)) u_settle_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (settle_load),
        .en   (state == SETTLE),
        .len  (settle_len),
        .term (settle_term)
    );

    sweep_interval_cnt #(.W(DWELL_W)) u_dwell_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (dwell_load),
        .en   (state == DWELL),
        .len  (cfg_dwell),
        .term (dwell_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        settle_load = 1'b0;
        dwell_load  = 1'b0;
        advance     = 1'b0;
        wrap        = 1'b0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    capture     = 1'b1;
                    settle_load = 1'b1;
                    next_state  = SETTLE;
                end
                SETTLE: if (settle_term) begin
                    dwell_load = 1'b1;
                    next_state = DWELL;
                end
                DWELL: if (dwell_term) begin
                    if (!last_point) begin
                        advance     = 1'b1;
                        settle_load = 1'b1;
                        next_state  = SETTLE;
                    end else if (loop_req) begin
                        wrap        = 1'b1;
                        settle_load = 1'b1;
                        next_state  = SETTLE;
                    end else begin
                        next_state = DONE;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fre_w      <= '0;
            point_idx  <= '0;
            ovf        <= 1'b0;
            wrap_done  <= 1'b0;
            cfg_start  <= '0;
            cfg_step   <= '0;
            cfg_settle <= '0;
            cfg_dwell  <= '0;
            last_idx   <= '0;
        end else begin
            wrap_done <= wrap;
            if (capture) begin
                cfg_start  <= f_start;
                cfg_step   <= f_step;
                cfg_settle <= settle_cycles;
                cfg_dwell  <= dwell_cycles;
                last_idx   <= (n_points == '0) ? '0 : n_points - IDX_W'(1);
                fre_w      <= f_start;
                point_idx  <= '0;
                ovf        <= 1'b0;
            end else if (advance) begin
                fre_w     <= step_sum.word;
                ovf       <= ovf | step_sum.sat;
                point_idx <= point_idx + IDX_W'(1);
            end else if (wrap) begin
                fre_w     <= cfg_start;
                point_idx <= '0;
            end
        end
    end

    // abort suppresses the completion pulses in the cycle it arrives.
    assign busy        = (state != IDLE);
    assign meas_window = (state == DWELL);
    assign point_valid = dwell_term && !abort;
    assign done        = ((state == DONE) || wrap_done) && !abort;

endmodule
